led_column_scanner: RTL

//  Upstream timing stage for led_array_driver. Generates its ena and column index x.

---
 rtl/led_column_scanner.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/led_column_scanner.sv
// Column scan timing, blanking and double-buffered frame store feeding led_array_driver.
// Optional macro LED_SCAN_BRIGHTNESS_EN adds a 4-bit PWM brightness input.
module led_column_scanner #(
    parameter int N           = 3,
    parameter int ON_TICKS    = 1000,
    parameter int BLANK_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [3:0]           brightness,
`endif
    input  logic [N*N-1:0]       cells_in,
    input  logic                 cells_valid,
    output logic                 cells_ready,
    output logic [N*N-1:0]       cells_out,
    output logic [$clog2(N):0]   x,
    output logic                 ena,
    output logic                 frame_start
);

    localparam int XW     = $clog2(N) + 1;
    localparam int MAX_T  = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int CW     = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
    localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("led_column_scanner: N must be in 1..8");
    end
    if (ON_TICKS < 1 || BLANK_TICKS < 1) begin : g_bad_ticks
        $error("led_column_scanner: ON_TICKS and BLANK_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        S_OFF,
        S_BLANK,
        S_ON
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic [N*N-1:0]  cells_out_q, cells_out_d;
    logic [N*N-1:0]  pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic            frame_start_q, frame_start_d;
    logic            boundary;
    logic            capture;
    logic            transfer;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        boundary = 1'b0;

        unique case (state_q)
            S_OFF: begin
                cnt_d = '0;
                x_d   = '0;
                if (run) begin
                    state_d  = S_BLANK;
                    boundary = 1'b1;
                end
            end
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (x_q == X_LAST) begin
                        x_d      = '0;
                        boundary = 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Dropping run aborts mid-column from any state.
        if (!run) begin
            state_d  = S_OFF;
            cnt_d    = '0;
            x_d      = '0;
            boundary = 1'b0;
        end
    end

    // Capture only into an empty buffer, so capture and transfer never coincide.
    always_comb begin
        frame_start_d = boundary;
        capture       = cells_valid && !pend_full_q;
        transfer      = pend_full_q && (boundary || (state_q == S_OFF));

        cells_out_d = transfer ? pend_q : cells_out_q;
        pend_d      = capture ? cells_in : pend_q;
        pend_full_d = pend_full_q;
        if (capture) begin
            pend_full_d = 1'b1;
        end else if (transfer) begin
            pend_full_d = 1'b0;
        end
    end

    // NOTE: every flop, including the frame buffers, is cleared by rst_n so a reset discards any pending frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_OFF;
            cnt_q         <= '0;
            x_q           <= '0;
            cells_out_q   <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            cells_out_q   <= cells_out_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [CW-1:0] duty_q, duty_d;

    // Duty is frozen on entry to ON so a brightness change never alters a lit column.
    always_comb begin
        duty_d = duty_q;
        if (state_q == S_BLANK && state_d == S_ON) begin
            duty_d = CW'(((int'(brightness) + 1) * ON_TICKS) >> 4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign ena = (state_q == S_ON) && (cnt_q < duty_q);
`else
    // NOTE: ena decodes the state register directly, so an async reset blanks the array in the same cycle.
    assign ena = (state_q == S_ON);
`endif

    assign cells_ready = !pend_full_q;
    assign cells_out   = cells_out_q;
    assign x           = x_q;
    assign frame_start = frame_start_q;

endmodule
